// File: rtl/dummy_accelerator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dummy_accelerator_pkg
// Description : Shared types and constants for the accelerator dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package dummy_accelerator_pkg;

    localparam int c_ORDER_DEPTH_DEFAULT = 8;
    localparam int c_UNIT_IDX_W          = 8;

    // Routing metadata kept per in-flight operation; the tag travels alongside.
    typedef struct packed {
        logic                    illegal;
        logic [c_UNIT_IDX_W-1:0] unit;
    } order_meta_t;

    function automatic order_meta_t make_meta(input logic [c_UNIT_IDX_W-1:0] unit,
                                              input logic                    illegal);
        order_meta_t m;
        m.illegal = illegal;
        m.unit    = unit;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_accelerator_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dummy_accelerator_order_fifo
// Description : Synchronous order FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_accelerator_order_fifo #(
    parameter int  DATA_W  = 8,
    parameter int  DEPTH   = 8,
    localparam int c_PTR_W = $clog2(DEPTH),
    localparam int c_CNT_W = c_PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [c_CNT_W-1:0] count_o
);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Full depends on stored occupancy only, so a same-cycle pop never frees a slot.
    assign full_o  = (r_count == c_CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dummy_accelerator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : dummy_accelerator_dispatcher
// Description : Issues ops to execution units and retires results in order.
// Revision    : 1.0 - initial release
// ============================================================================
module dummy_accelerator_dispatcher
    import dummy_accelerator_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  IMM_WIDTH   = 11,
    parameter int  NUM_UNITS   = 2,
    parameter int  ORDER_DEPTH = c_ORDER_DEPTH_DEFAULT,
    parameter type TagType_t   = logic,
    localparam int c_SEL_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic [c_SEL_W-1:0]               unit_sel_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [WIDTH-1:0]                 rs1_value_i,
    input  logic [IMM_WIDTH-1:0]             imm_i,
    input  TagType_t                         tag_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [WIDTH-1:0]                 result_o,
    output TagType_t                         tag_o,
    output logic                             error_o,
    output logic                             busy_o,
    output logic [NUM_UNITS-1:0]             unit_valid_o,
    input  logic [NUM_UNITS-1:0]             unit_ready_i,
    output logic [WIDTH-1:0]                 unit_rs1_o,
    output logic [IMM_WIDTH-1:0]             unit_imm_o,
    output TagType_t                         unit_tag_o,
    output logic                             unit_flush_o,
    input  logic [NUM_UNITS-1:0]             unit_valid_i,
    output logic [NUM_UNITS-1:0]             unit_ready_o,
    input  logic [NUM_UNITS-1:0][WIDTH-1:0]  unit_result_i,
    input  TagType_t [NUM_UNITS-1:0]         unit_tag_i
);

    localparam int c_TAG_W   = $bits(TagType_t);
    localparam int c_META_W  = $bits(order_meta_t);
    localparam int c_ENTRY_W = c_META_W + c_TAG_W;
    localparam int c_CNT_W   = $clog2(ORDER_DEPTH) + 1;

    logic                 w_gate;
    logic                 w_sel_illegal;
    logic                 w_sel_ready;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head_entry;
    order_meta_t          w_head_meta;
    TagType_t             w_head_tag;

    // Reset and flush both mask every handshake in the cycle they are asserted.
    assign w_gate        = !rst_i && !flush_i;
    assign w_sel_illegal = (32'(unit_sel_i) >= NUM_UNITS);

    assign unit_rs1_o   = rs1_value_i;
    assign unit_imm_o   = imm_i;
    assign unit_tag_o   = tag_i;
    assign unit_flush_o = flush_i;

    always_comb begin
        w_sel_ready  = 1'b0;
        unit_valid_o = '0;
        for (int s = 0; s < NUM_UNITS; s++) begin
            if (unit_sel_i == c_SEL_W'(s)) begin
                w_sel_ready     = unit_ready_i[s];
                unit_valid_o[s] = w_gate && valid_i && !w_full;
            end
        end
    end

    assign ready_o      = w_gate && !w_full && (w_sel_illegal || w_sel_ready);
    assign w_push       = valid_i && ready_o;
    assign w_push_entry = {make_meta(c_UNIT_IDX_W'(unit_sel_i), w_sel_illegal), tag_i};
    assign w_head_meta  = w_head_entry[c_ENTRY_W-1 -: c_META_W];
    assign w_head_tag   = w_head_entry[c_TAG_W-1:0];

    // Only the unit owning the oldest op is granted, which enforces in-order retirement.
    always_comb begin
        valid_o      = 1'b0;
        result_o     = '0;
        tag_o        = '0;
        error_o      = 1'b0;
        unit_ready_o = '0;
        if (w_gate && !w_empty) begin
            if (w_head_meta.illegal) begin
                valid_o = 1'b1;
                tag_o   = w_head_tag;
                error_o = 1'b1;
            end else begin
                for (int s = 0; s < NUM_UNITS; s++) begin
                    if (w_head_meta.unit == c_UNIT_IDX_W'(s)) begin
                        valid_o         = unit_valid_i[s];
                        result_o        = unit_result_i[s];
                        tag_o           = unit_tag_i[s];
                        unit_ready_o[s] = ready_i;
                    end
                end
            end
        end
    end

    assign w_pop  = valid_o && ready_i;
    assign busy_o = !rst_i && (w_count != '0);

    dummy_accelerator_order_fifo #(
        .DATA_W (c_ENTRY_W),
        .DEPTH  (ORDER_DEPTH)
    ) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_push_entry),
        .data_o  (w_head_entry),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

endmodule
`default_nettype wire
